// File: rtl/cv32e40p_fetch_fifo_ft.sv
// cv32e40p_fetch_fifo_ft
//   Parity-protected instruction response FIFO sitting between the OBI
//   instruction response path and the IF-stage prefetch buffer. It buffers
//   rdata/err beats, flushes on branch and checks a per-entry parity bit when
//   the entry reaches the head. Corrupted entries are flagged and counted, but
//   they are still delivered unchanged.
//
// Optional feature: define FETCH_FIFO_PARITY_EN to store a parity bit per entry.
//   Without it, parity_err_o and err_cnt_o are tied to 0.
//
// Parameters
//   DEPTH      number of entries (>=2, need not be a power of 2)
//   CNT_WIDTH  width of the saturating parity-error counter
//
// Ports
//   clk, rst_n     core clock, synchronous active-low reset
//   clear_i        flush all entries (branch / pc_set)
//   in_valid_i     response beat valid; in_ready_o = space available or head popping
//   in_rdata_i     instruction word; in_err_i = bus error for this beat
//   out_valid_o    head entry valid; out_ready_i = consumer pops the head
//   out_rdata_o    head word; out_err_o = head bus error (both 0 while empty)
//   parity_err_o   head entry fails its parity check
//   cnt_o          occupancy
//   overflow_o     sticky: a beat arrived while no space was available
//   err_cnt_o      saturating count of popped entries with a parity error
module cv32e40p_fetch_fifo_ft #(
  parameter int DEPTH     = 2,
  parameter int CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [31:0]                in_rdata_i,
  input  logic                       in_err_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_rdata_o,
  output logic                       out_err_o,
  output logic                       parity_err_o,
  output logic [$clog2(DEPTH+1)-1:0] cnt_o,
  output logic                       overflow_o,
  output logic [CNT_WIDTH-1:0]       err_cnt_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;
  logic          push;
  logic          pop;

  logic [31:0]   mem_rdata [DEPTH];
  logic          mem_err   [DEPTH];

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-2 depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign out_valid_o = (cnt_q != '0);
  // A full FIFO can still accept when the head leaves in the same cycle.
  assign in_ready_o  = (cnt_q < CW'(DEPTH)) | out_ready_i;
  assign push        = in_valid_i & in_ready_o & ~clear_i;
  assign pop         = out_valid_o & out_ready_i & ~clear_i;

  assign cnt_o       = cnt_q;
  assign overflow_o  = ovf_q;
  assign out_rdata_o = out_valid_o ? mem_rdata[rd_ptr] : 32'h0;
  assign out_err_o   = out_valid_o ? mem_err[rd_ptr] : 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (in_valid_i && !in_ready_o && !clear_i) begin
        ovf_q <= 1'b1;
      end
      if (clear_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt_q  <= '0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage is intentionally not reset; the occupancy count gates all reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rdata[wr_ptr] <= in_rdata_i;
      mem_err[wr_ptr]   <= in_err_i;
    end
  end

`ifdef FETCH_FIFO_PARITY_EN
  logic                 mem_par [DEPTH];
  logic                 head_par_bad;
  logic [CNT_WIDTH-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_par[wr_ptr] <= ^{in_err_i, in_rdata_i};
    end
  end

  assign head_par_bad = (^{mem_err[rd_ptr], mem_rdata[rd_ptr]}) != mem_par[rd_ptr];
  assign parity_err_o = out_valid_o & head_par_bad;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (pop && parity_err_o && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign parity_err_o = 1'b0;
  assign err_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_fetch_fifo_ft.sv
module tb_cv32e40p_fetch_fifo_ft;

  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, in_err, out_ready;
  logic [31:0] in_rdata;

  logic        rdy2, val2, er2, pe2, ov2;
  logic [31:0] rd2;
  logic [1:0]  cnt2;
  logic [7:0]  ec2;
  logic        rdy3, val3, er3, pe3, ov3;
  logic [31:0] rd3;
  logic [1:0]  cnt3;
  logic [7:0]  ec3;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: one queue of {bad, err, rdata} per instance
  int          md [2] = '{2, 3};
  logic [33:0] mq [2][$];
  logic        movf [2];
  int          mec [2];

  logic [31:0] pop_log3 [$];
  int          max_cnt3;

  always #5 clk = ~clk;

  cv32e40p_fetch_fifo_ft #(.DEPTH(2), .CNT_WIDTH(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(rdy2), .in_rdata_i(in_rdata), .in_err_i(in_err),
    .out_valid_o(val2), .out_ready_i(out_ready), .out_rdata_o(rd2), .out_err_o(er2),
    .parity_err_o(pe2), .cnt_o(cnt2), .overflow_o(ov2), .err_cnt_o(ec2)
  );

  cv32e40p_fetch_fifo_ft #(.DEPTH(3), .CNT_WIDTH(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(rdy3), .in_rdata_i(in_rdata), .in_err_i(in_err),
    .out_valid_o(val3), .out_ready_i(out_ready), .out_rdata_o(rd3), .out_err_o(er3),
    .parity_err_o(pe3), .cnt_o(cnt3), .overflow_o(ov3), .err_cnt_o(ec3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input int i, input logic rdy, input logic val,
                            input logic [31:0] rd, input logic er, input logic pe,
                            input logic [1:0] cn, input logic ov, input logic [7:0] ec);
    int          sz;
    logic [33:0] h;
    string       p;
    sz = mq[i].size();
    h  = (sz != 0) ? mq[i][0] : 34'h0;
    p  = $sformatf("d%0d_", md[i]);
    chk({p, "in_ready"},  32'(rdy), 32'((sz < md[i]) || out_ready));
    chk({p, "out_valid"}, 32'(val), 32'(sz != 0));
    chk({p, "rdata"},     rd,       h[31:0]);
    chk({p, "err"},       32'(er),  32'(h[32]));
`ifdef FETCH_FIFO_PARITY_EN
    chk({p, "parity"},    32'(pe),  32'(h[33]));
`else
    chk({p, "parity"},    32'(pe),  32'h0);
`endif
    chk({p, "cnt"},       32'(cn),  32'(sz));
    chk({p, "overflow"},  32'(ov),  32'(movf[i]));
    chk({p, "err_cnt"},   32'(ec),  32'(mec[i]));
  endtask

  task automatic model_update();
    int          sz;
    logic        rdy, push, pop;
    logic [33:0] h;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mq[i].delete();
        movf[i] = 1'b0;
        mec[i]  = 0;
      end else begin
        sz   = mq[i].size();
        rdy  = (sz < md[i]) || out_ready;
        push = in_valid && rdy && !clear;
        pop  = (sz != 0) && out_ready && !clear;
        if (in_valid && !rdy && !clear) movf[i] = 1'b1;
        if (clear) begin
          mq[i].delete();
        end else begin
          if (pop) begin
            h = mq[i][0];
            if (h[33] && mec[i] < 255) mec[i]++;
            void'(mq[i].pop_front());
          end
          if (push) mq[i].push_back({1'b0, in_err, in_rdata});
        end
      end
    end
  endtask

  // inputs are set before the call; outputs checked mid-low-phase, then the edge
  task automatic cycle(input bit do_chk = 1);
    #1;
    if (do_chk) begin
      check_inst(0, rdy2, val2, rd2, er2, pe2, cnt2, ov2, ec2);
      check_inst(1, rdy3, val3, rd3, er3, pe3, cnt3, ov3, ec3);
      if (val3 && out_ready && !clear && rst_n) pop_log3.push_back(rd3);
      if (int'(cnt3) > max_cnt3) max_cnt3 = int'(cnt3);
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic c);
    in_valid  = v;
    in_rdata  = d;
    in_err    = 1'b0;
    out_ready = r;
    clear     = c;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 32'h0, 0, 0);
    max_cnt3 = 0;
    @(negedge clk);
    cycle(0);
    cycle(0);
    rst_n = 1'b1;
    #1;
    chk("rst_cnt",      32'(cnt2), 32'h0);
    chk("rst_valid",    32'(val2), 32'h0);
    chk("rst_in_ready", 32'(rdy2), 32'h1);
    chk("rst_overflow", 32'(ov2),  32'h0);
    chk("rst_err_cnt",  32'(ec2),  32'h0);
    chk("rst_rdata",    rd2,       32'h0);

    // DEPTH=3 wrap: A0..A6, consumer ready from the second cycle
    pop_log3.delete();
    max_cnt3 = 0;
    for (int k = 0; k < 7; k++) begin
      drive(1, 32'hA0 + k, (k >= 1), 0);
      cycle();
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 32'h0, 1, 0);
      cycle();
    end
    chk("wrap_pop_count", 32'(pop_log3.size()), 32'd7);
    for (int k = 0; k < 7 && k < pop_log3.size(); k++)
      chk($sformatf("wrap_pop%0d", k), pop_log3[k], 32'hA0 + k);
    chk("wrap_cnt_le3", 32'(max_cnt3 <= 3), 32'h1);

    // full and simultaneous push/pop on DEPTH=2
    drive(0, 32'h0, 0, 1); cycle();
    drive(1, 32'h11, 0, 0); cycle();
    drive(1, 32'h22, 0, 0); cycle();
    drive(1, 32'h33, 1, 0);
    #1;
    chk("full_head",     rd2,        32'h11);
    chk("full_in_ready", 32'(rdy2),  32'h1);
    cycle();
    chk("full_cnt",      32'(cnt2),  32'h2);
    chk("full_newhead",  rd2,        32'h22);
    chk("full_overflow", 32'(ov2),   32'h0);

    // overflow: drop and sticky, also across clear
    drive(0, 32'h0, 0, 1); cycle();
    drive(1, 32'h11, 0, 0); cycle();
    drive(1, 32'h22, 0, 0); cycle();
    drive(1, 32'h44, 0, 0); cycle();
    chk("ovf_set",  32'(ov2),  32'h1);
    chk("ovf_cnt",  32'(cnt2), 32'h2);
    chk("ovf_head", rd2,       32'h11);
    drive(0, 32'h0, 0, 0); cycle();
    chk("ovf_keep_head", rd2, 32'h11);
    drive(0, 32'h0, 0, 1); cycle();
    chk("ovf_after_clear", 32'(ov2),  32'h1);
    chk("clear_cnt",       32'(cnt2), 32'h0);

    // clear racing with push and pop
    drive(1, 32'h66, 0, 0); cycle();
    chk("race_pre_cnt", 32'(cnt2), 32'h1);
    drive(1, 32'h55, 1, 1); cycle();
    chk("race_cnt",   32'(cnt2), 32'h0);
    chk("race_valid", 32'(val2), 32'h0);
    drive(0, 32'h0, 0, 0); cycle();
    chk("race_not_stored", 32'(val2), 32'h0);

`ifdef FETCH_FIFO_PARITY_EN
    for (int k = 0; k < 256; k++) begin
      drive(0, 32'h0, 0, 1); cycle();
      drive(1, 32'h1000 + k, 0, 0); cycle();
      dut2.mem_rdata[0][5] = ~dut2.mem_rdata[0][5];
      dut3.mem_rdata[0][5] = ~dut3.mem_rdata[0][5];
      for (int i = 0; i < 2; i++) mq[i][0] = mq[i][0] ^ ((34'h1 << 33) | 34'h20);
      drive(0, 32'h0, 1, 0);
      #1;
      chk("par_flag",  32'(pe2), 32'h1);
      chk("par_rdata", rd2,      (32'h1000 + k) ^ 32'h20);
      cycle();
      if (k == 0) chk("par_err_cnt1", 32'(ec2), 32'h1);
    end
    chk("par_err_cnt_sat", 32'(ec2), 32'hFF);
`else
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'h0BAD_0000 | k, 0, 0); cycle();
      chk("nopar_flag", 32'(pe2), 32'h0);
      drive(0, 32'h0, 1, 0); cycle();
      chk("nopar_err_cnt", 32'(ec2), 32'h0);
    end
`endif

    // randomized traffic, including rare clears and resets
    for (int k = 0; k < 3000; k++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      in_valid  = $urandom_range(0, 2) != 0;
      in_rdata  = $urandom;
      in_err    = ($urandom_range(0, 7) == 0);
      out_ready = $urandom_range(0, 1);
      clear     = ($urandom_range(0, 15) == 0);
      cycle();
    end
    rst_n = 1'b1;
    drive(0, 32'h0, 0, 0);
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
